// File: rtl/dmem_initiator.sv
// Data-memory bus initiator: converts single core load/store requests into
// cmd/read/write channel handshakes with byte-lane steering and load extension.
module dmem_initiator #(
    parameter int p_ADDR_BITS = 32,
    parameter int p_DATA_BITS = 32,
    parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [p_ADDR_BITS-1:0] req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [p_DATA_BITS-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic [p_DATA_BITS-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [p_ADDR_BITS-1:0] mem_addr,
    output logic                   mem_cmd,
    output logic [1:0]             mem_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_r_ready,
    input  logic                   mem_r_valid,
    input  logic [p_DATA_BITS-1:0] mem_r_data,
    input  logic                   mem_r_resp,
    output logic                   mem_w_valid,
    input  logic                   mem_w_ready,
    output logic [p_STRB_BITS-1:0] mem_w_strb,
    output logic [p_DATA_BITS-1:0] mem_w_data,
    input  logic                   mem_w_resp
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_RDATA, S_WDATA, S_RESP} state_t;

    state_t state, state_nxt;

    logic                   accept;
    logic                   misal;
    logic                   wr_cur;
    logic [1:0]             off_q;
    logic                   uns_q;
    logic [p_STRB_BITS-1:0] strb_d;
    logic [p_DATA_BITS-1:0] wdata_d;
    logic [p_DATA_BITS-1:0] sh;
    logic [p_DATA_BITS-1:0] rd_ext;

    logic                   req_ready_d, rsp_valid_d, rsp_err_d;
    logic                   mem_valid_d, mem_w_valid_d, mem_r_ready_d;
    logic [p_DATA_BITS-1:0] rsp_rdata_d;

    // req_ready is only ever high in IDLE, so accept implies IDLE
    assign accept = req_valid && req_ready;
    assign wr_cur = accept ? req_write : mem_cmd;

    always_comb begin
        misal = 1'b0;
        case (req_size)
            2'd1:    misal = req_addr[0];
            2'd2:    misal = |req_addr[1:0];
            2'd3:    misal = 1'b1;
            default: misal = 1'b0;
        endcase
    end

    always_comb begin
        strb_d  = '1;
        wdata_d = req_wdata;
        case (req_size)
            2'd0: begin
                strb_d  = p_STRB_BITS'(1) << req_addr[1:0];
                wdata_d = {p_STRB_BITS{req_wdata[7:0]}};
            end
            2'd1: begin
                strb_d  = p_STRB_BITS'(3) << req_addr[1:0];
                wdata_d = {(p_STRB_BITS/2){req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load data is lane-shifted down by the latched byte offset, then extended
    assign sh = mem_r_data >> {off_q, 3'b000};

    always_comb begin
        rd_ext = sh;
        case (mem_size)
            2'd0:    rd_ext = {{(p_DATA_BITS-8){~uns_q & sh[7]}}, sh[7:0]};
            2'd1:    rd_ext = {{(p_DATA_BITS-16){~uns_q & sh[15]}}, sh[15:0]};
            default: rd_ext = sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = misal ? S_RESP : S_CMD;
            S_CMD:   if (mem_ready) begin
                         if (!mem_cmd)        state_nxt = S_RDATA;
                         else if (mem_w_ready) state_nxt = S_RESP;
                         else                  state_nxt = S_WDATA;
                     end
            S_WDATA: if (mem_w_ready) state_nxt = S_RESP;
            S_RDATA: if (mem_r_valid) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the state being entered
    always_comb begin
        req_ready_d   = (state_nxt == S_IDLE);
        mem_valid_d   = (state_nxt == S_CMD);
        mem_w_valid_d = (state_nxt == S_WDATA) || (state_nxt == S_CMD && wr_cur);
        mem_r_ready_d = (state_nxt == S_RDATA);
        rsp_valid_d   = (state_nxt == S_RESP);
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;
        case (state)
            S_IDLE:  if (accept && misal) rsp_err_d = 1'b1;
            S_CMD:   if (mem_cmd && mem_ready && mem_w_ready) rsp_err_d = mem_w_resp;
            S_WDATA: if (mem_w_ready) rsp_err_d = mem_w_resp;
            S_RDATA: if (mem_r_valid) begin
                         rsp_err_d   = mem_r_resp;
                         rsp_rdata_d = mem_r_resp ? '0 : rd_ext;
                     end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_valid   <= 1'b0;
            mem_w_valid <= 1'b0;
            mem_r_ready <= 1'b0;
            mem_addr    <= '0;
            mem_cmd     <= 1'b0;
            mem_size    <= '0;
            mem_w_strb  <= '0;
            mem_w_data  <= '0;
            off_q       <= '0;
            uns_q       <= 1'b0;
        end else begin
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_rdata   <= rsp_rdata_d;
            mem_valid   <= mem_valid_d;
            mem_w_valid <= mem_w_valid_d;
            mem_r_ready <= mem_r_ready_d;
            if (accept) begin
                mem_addr   <= {req_addr[p_ADDR_BITS-1:2], 2'b00};
                mem_cmd    <= req_write;
                mem_size   <= req_size;
                mem_w_strb <= strb_d;
                mem_w_data <= wdata_d;
                off_q      <= req_addr[1:0];
                uns_q      <= req_unsigned;
            end
        end
    end

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator: random and directed loads/stores against
// a byte-level memory reference model, with a delay/error-injecting responder.
module tb_dmem_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic        mem_cmd, mem_valid, mem_ready, mem_r_ready, mem_r_valid, mem_r_resp;
    logic        mem_w_valid, mem_w_ready, mem_w_resp;
    logic [1:0]  mem_size;
    logic [3:0]  mem_w_strb;

    always #5 clk = ~clk;

    dmem_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_r_ready(mem_r_ready), .mem_r_valid(mem_r_valid),
        .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data), .mem_w_resp(mem_w_resp)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        cmd;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] data;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];

    int total = 0, bad = 0, cyc = 0;
    int c_dly = 0, w_xtra = 0, r_dly = 0;
    bit err_inj = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] bus_mem [int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        int unsigned k = int'(a >> 2);
        return bus_mem.exists(k) ? bus_mem[k] : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        total++;
        bad++;
        $display("FAIL %s", msg);
    endtask

    // Present one request, push the expected bus command and response
    task automatic issue(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input bit uns, input logic [31:0] wd);
        int nb, off, guard;
        bit mis;
        rsp_t r;
        bus_t b;
        logic [31:0] w, v;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            fail("accept_timeout: req_ready never rose");
            req_valid = 1'b0;
            return;
        end
        off = int'(a[1:0]);
        nb  = 1 << sz;
        mis = (sz == 2'd3) || ((off % nb) != 0);
        r.acc = cyc;
        r.rdata = '0;
        if (mis) begin
            r.err = 1'b1;
            r.lat = 1;
        end else begin
            r.err = err_inj;
            b.addr = a & ~32'h3;
            b.cmd = wr;
            b.size = sz;
            b.strb = '0;
            b.data = '0;
            w = ref_rd(a);
            for (int i = 0; i < 4; i++) begin
                b.strb[i] = (i >= off) && (i < off + nb);
                b.data[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
            if (wr) begin
                r.lat = 2 + c_dly + w_xtra;
                if (!err_inj) begin
                    for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
                    ref_mem[int'(a >> 2)] = w;
                end
            end else begin
                r.lat = 3 + c_dly + r_dly;
                if (!err_inj) begin
                    v = '0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
                    if (!uns && v[8*nb-1])
                        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                    r.rdata = v;
                end
            end
            bus_q.push_back(b);
        end
        rsp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input bit uns, input logic [31:0] wd);
        int guard = 0;
        issue(wr, a, sz, uns, wd);
        while (rsp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_q.size() != 0) begin
            fail("rsp_timeout: no response within 200 cycles");
            rsp_q.delete();
            bus_q.delete();
        end
        @(negedge clk);
    endtask

    // Responder: delays counted in cycles of the relevant valid, errors per request
    initial begin
        int cnt_c = 0, cnt_w = 0, cnt_r = 0;
        logic [31:0] w;
        mem_ready = 0; mem_w_ready = 0; mem_w_resp = 0;
        mem_r_valid = 0; mem_r_data = 0; mem_r_resp = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mem_ready = 0; mem_w_ready = 0; mem_r_valid = 0;
                cnt_c = 0; cnt_w = 0; cnt_r = 0;
            end else begin
                if (mem_valid) begin
                    mem_ready = (cnt_c >= c_dly);
                    cnt_c++;
                end else begin
                    mem_ready = 0;
                    cnt_c = 0;
                end
                if (mem_w_valid) begin
                    mem_w_ready = (cnt_w >= c_dly + w_xtra);
                    cnt_w++;
                    mem_w_resp = mem_w_ready ? err_inj : 1'($urandom_range(0, 1));
                    if (mem_w_ready && !err_inj) begin
                        w = bus_rd(mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (mem_w_strb[i]) w[8*i +: 8] = mem_w_data[8*i +: 8];
                        bus_mem[int'(mem_addr >> 2)] = w;
                    end
                end else begin
                    mem_w_ready = 0;
                    cnt_w = 0;
                    mem_w_resp = 1'($urandom_range(0, 1));
                end
                if (mem_r_ready) begin
                    mem_r_valid = (cnt_r >= r_dly);
                    cnt_r++;
                    mem_r_data = mem_r_valid ? bus_rd(mem_addr) : $urandom;
                    mem_r_resp = mem_r_valid ? err_inj : 1'($urandom_range(0, 1));
                end else begin
                    // junk read beats outside RDATA must be ignored
                    cnt_r = 0;
                    mem_r_valid = 1'($urandom_range(0, 1));
                    mem_r_data = $urandom;
                    mem_r_resp = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Bus monitor: command payload checked every cycle it is presented
    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            #1;
            if (rst && mem_valid) begin
                if (bus_q.size() == 0) begin
                    fail("stray_cmd: mem_valid=1 expected 0");
                end else begin
                    b = bus_q[0];
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_cmd", 32'(mem_cmd), 32'(b.cmd));
                    chk("mem_size", 32'(mem_size), 32'(b.size));
                    if (b.cmd) begin
                        chk("mem_w_valid", 32'(mem_w_valid), 32'h1);
                        chk("mem_w_strb", 32'(mem_w_strb), 32'(b.strb));
                        chk("mem_w_data", mem_w_data, b.data);
                    end
                    if (mem_ready) void'(bus_q.pop_front());
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    fail("stray_rsp: rsp_valid=1 expected 0");
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(r.err));
                    chk("rsp_latency", 32'(cyc - r.acc), 32'(r.lat));
                    last_rdata = rsp_rdata;
                    last_err = rsp_err;
                end
            end
        end
    end

    function automatic int outs_ones();
        return $countones({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_cmd,
                           mem_size, mem_valid, mem_r_ready, mem_w_valid, mem_w_strb,
                           mem_w_data});
    endfunction

    initial begin
        int guard;
        logic [1:0] sz;
        ref_mem[32'h100 >> 2] = 32'h8765_4321;
        bus_mem[32'h100 >> 2] = 32'h8765_4321;

        repeat (3) @(negedge clk);
        chk("reset_outputs_ones", 32'(outs_ones()), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'h1);

        run_req(0, 32'h100, 2'd2, 0, 0);
        chk("ld_word", last_rdata, 32'h8765_4321);
        run_req(0, 32'h103, 2'd0, 0, 0);
        chk("ld_byte_s", last_rdata, 32'hFFFF_FF87);
        run_req(0, 32'h103, 2'd0, 1, 0);
        chk("ld_byte_u", last_rdata, 32'h0000_0087);
        run_req(0, 32'h102, 2'd1, 0, 0);
        chk("ld_half_s", last_rdata, 32'hFFFF_8765);

        run_req(1, 32'h201, 2'd0, 0, 32'h0000_00AB);
        run_req(1, 32'h202, 2'd1, 0, 32'h0000_1234);
        run_req(0, 32'h200, 2'd2, 0, 0);
        chk("ld_after_st", last_rdata, 32'h1234_AB00);

        c_dly = 5;
        run_req(0, 32'h100, 2'd2, 0, 0);
        c_dly = 0; w_xtra = 3;
        run_req(1, 32'h204, 2'd2, 0, 32'hCAFE_F00D);
        w_xtra = 0;

        run_req(0, 32'h101, 2'd1, 0, 0);
        chk("misal_half_err", 32'(last_err), 32'h1);
        run_req(1, 32'h104, 2'd3, 0, 32'h1);
        chk("size3_err", 32'(last_err), 32'h1);
        err_inj = 1'b1;
        run_req(0, 32'h100, 2'd2, 0, 0);
        chk("bus_err_flag", 32'(last_err), 32'h1);
        chk("bus_err_rdata", last_rdata, 32'h0);
        err_inj = 1'b0;

        // Reset while waiting for read data
        r_dly = 1000;
        issue(0, 32'h100, 2'd2, 0, 0);
        guard = 0;
        while (!mem_r_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!mem_r_ready) fail("rdata_wait_timeout: mem_r_ready never rose");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midop_reset_outputs_ones", 32'(outs_ones()), 32'h0);
        rsp_q.delete();
        bus_q.delete();
        r_dly = 0;
        repeat (3) @(negedge clk);
        chk("held_reset_outputs_ones", 32'(outs_ones()), 32'h0);
        rst = 1'b1;
        run_req(0, 32'h204, 2'd2, 0, 0);
        chk("post_reset_ld", last_rdata, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            c_dly = $urandom_range(0, 3);
            w_xtra = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            r_dly = $urandom_range(0, 3);
            err_inj = ($urandom_range(0, 9) == 0);
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_req(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 63)), sz,
                    1'($urandom_range(0, 1)), $urandom);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        fail("watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_initiator.md
Name: dmem_initiator

Overview:
- Initiator (master) end of the core's data-memory bus: converts single load/store requests from the core pipeline into the cmd/read/write channel handshake that memory responders implement.
- Word-aligns the address, generates byte strobes and replicated write data, and extracts and sign-/zero-extends read data.
- Flags misaligned accesses and bus error responses.
- Sits between the core LSU stage and the dmem port of the memory model/controller.

Parameters:
p_ADDR_BITS, 32, address width
p_DATA_BITS, 32, data width (only 32 supported)
p_STRB_BITS, p_DATA_BITS/8, write strobe width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (rst==0 resets)
req_valid  in  1  core request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_write  in  1  1=store, 0=load
req_addr  in  p_ADDR_BITS  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  zero-extend load result
req_wdata  in  p_DATA_BITS  store data, LSB-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  p_DATA_BITS  extended load data (0 for stores/errors)
rsp_err  out  1  misaligned/illegal or bus error; valid with rsp_valid
mem_addr  out  p_ADDR_BITS  word-aligned address {req_addr[hi:2],2'b00}
mem_cmd  out  1  0=read, 1=write
mem_size  out  2  req_size, passed through
mem_valid  out  1  command valid
mem_ready  in  1  command accepted
mem_r_ready  out  1  read data accept
mem_r_valid  in  1  read data valid
mem_r_data  in  p_DATA_BITS  read word
mem_r_resp  in  1  read error
mem_w_valid  out  1  write data valid
mem_w_ready  in  1  write data accepted
mem_w_strb  out  p_STRB_BITS  byte strobes
mem_w_data  out  p_DATA_BITS  replicated write data
mem_w_resp  in  1  write error

Behaviour:
- Reset (rst==0, async):
  - State goes to IDLE. All outputs are 0: req_ready, rsp_*, mem_valid, mem_w_valid, mem_r_ready, mem_addr/strb/data.
  - An in-flight transaction is dropped with no response.
- All mem_* and rsp_* outputs are registered.
- States:
  - IDLE: req_ready=1.
  - CMD, RDATA, WDATA, RESP: req_ready=0.
- IDLE, on accept:
  - Latch addr, size, write, unsigned.
  - Misaligned if size==3, if size==1 && addr[0], or if size==2 && addr[1:0]!=0. A misaligned request goes to RESP with err=1 and makes no bus access.
  - Otherwise go to CMD. mem_valid=1 from the next cycle; for a store, mem_w_valid=1 in the same cycle.
- CMD: mem_valid and mem_w_valid hold with stable payload until the handshake completes.
  - Load, on mem_ready: drop mem_valid and go to RDATA.
  - Store, on mem_ready && mem_w_ready: drop both valids, capture mem_w_resp, go to RESP.
  - Store, on mem_ready only: drop mem_valid, keep mem_w_valid, go to WDATA.
- WDATA: on mem_w_ready, drop mem_w_valid, capture mem_w_resp, go to RESP.
- RDATA: mem_r_ready=1. On mem_r_valid:
  - Capture mem_r_resp and the extracted data; drop mem_r_ready; go to RESP.
  - A mem_r_valid seen while in any other state is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. Back-to-back: the next request can be accepted in the cycle after the RESP cycle.
- Write strobes and data, where off=addr[1:0]:
  - byte: strb=4'b0001<<off, data={4{wdata[7:0]}}
  - half: strb=4'b0011<<off, data={2{wdata[15:0]}}
  - word: strb=4'b1111, data=wdata
- Read extraction: sh=mem_r_data>>(8*off). byte = sh[7:0], half = sh[15:0]; sign-extend unless req_unsigned; word = sh.
- rsp_rdata is 0 when rsp_err=1 or for stores.
- Minimum latency, load, accept at cycle 0 with a zero-wait responder:
  - mem_valid in cycle 1, RDATA in cycle 2.
  - mem_r_valid sampled in cycle 2, rsp_valid in cycle 3.
- Store with a zero-wait responder: rsp_valid in cycle 2.

Test Plan:
- Word load: memory word 0x8765_4321 at 0x100; load addr 0x100 size 2 -> mem_addr=0x100, mem_cmd=0, rsp_rdata=0x87654321, err=0, rsp_valid 3 cycles after accept.
- Byte/half loads from the same word:
  - addr 0x103 size 0 signed -> 0xFFFF_FF87
  - addr 0x103 size 0 unsigned -> 0x0000_0087
  - addr 0x102 size 1 signed -> 0xFFFF_8765
- Stores:
  - addr 0x201 byte wdata 0xAB -> mem_addr 0x200, strb 4'b0010, data 0xABABABAB
  - addr 0x202 half 0x1234 -> strb 4'b1100, data 0x12341234
  - read back of 0x200 -> 0x1234AB00 (word pre-zeroed)
- Backpressure:
  - mem_ready held 0 for 5 cycles -> mem_valid and payload stable throughout.
  - mem_w_ready delayed 3 cycles past mem_ready -> WDATA path taken, single rsp pulse.
- Errors:
  - half at 0x101 -> rsp_err=1, no mem_valid ever.
  - size 3 -> same.
  - mem_r_resp=1 on a load -> rsp_err=1, rsp_rdata=0.
- Reset mid-op: rst low while in RDATA -> all outputs 0 immediately, no rsp_valid. After release, a new request completes normally.
